// File: rtl/lcd1602_sequencer.sv
// lcd1602_sequencer: autonomous HD44780/LCD1602 write sequencer fed by a small byte FIFO.
// Ports: in_clock/rst (async active-low); wr_req/wr_rs/wr_data push one byte per strobe;
//   clr_ovf clears the sticky overflow flag; fifo_level/busy/overflow/init_done report status;
//   lcd_e/lcd_rs/lcd_rw/lcd_d drive the panel (write-only, lcd_rw tied low).

// Generic FIFO: DEPTH words of W bits, pointers wrap modulo DEPTH, registered level.
// Latency: a pushed word is at the head (and counted in level) the cycle after the push.
// Backpressure: push_rdy low when full unless a pop is accepted in the same cycle.
module lcd1602_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                   in_clock,
    input  logic                   rst,
    input  logic                   push_vld,
    output logic                   push_rdy,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic                   pop_rdy,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          push_acc;
    logic          pop_acc;

    assign pop_rdy  = (level_q != '0);
    assign pop_acc  = pop_vld && pop_rdy;
    // When full, the slot being read this cycle is the one the write lands in.
    assign push_rdy = (level_q != LW'(DEPTH)) || pop_acc;
    assign push_acc = push_vld && push_rdy;
    assign head_dat = mem_q[rd_ptr_q];
    assign level    = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_acc) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge in_clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing is read before the pointers say it was written.
    always_ff @(posedge in_clock) begin
        mem_q <= mem_d;
    end
endmodule

// LCD1602 sequencer: power-on init, then drains FIFO bytes as timed RS/E/D write cycles.
// Latency: popped byte on RS/D next cycle, E rises T_SU later, next pop after T_EH+T_HOLD+exec wait.
// Backpressure: none toward the CPU; pushes to a full FIFO are dropped and flagged in overflow.
module lcd1602_sequencer #(
    parameter int DEPTH       = 4,
    parameter int T_SU        = 2,
    parameter int T_EH        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 888,
    parameter int T_EXEC_LONG = 36480,
    parameter int T_PWRUP     = 960000,
    parameter bit INIT_EN     = 1'b1,
    parameter int CW          = 20
) (
    input  logic                   in_clock,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic                   wr_rs,
    input  logic [7:0]             wr_data,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   init_done,
    output logic                   lcd_e,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic [7:0]             lcd_d
);
    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
    } lcd_entry_t;

    // The init-load step is folded into the exit of PWRUP/EXEC, so an init byte
    // reaches RS/D on the same edge its preceding wait expires.
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_EXEC
    } state_t;

    localparam state_t         ST_RESET  = INIT_EN ? ST_PWRUP : ST_IDLE;
    localparam logic [CW-1:0]  CNT_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0]  CNT_SU    = CW'(T_SU - 1);
    localparam logic [CW-1:0]  CNT_EH    = CW'(T_EH - 1);
    localparam logic [CW-1:0]  CNT_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0]  CNT_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0]  CNT_LONG  = CW'(T_EXEC_LONG - 1);
    localparam logic [2:0]     INIT_LEN  = 3'd6;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;  // function set, 8-bit, 2 lines
            3'd3:             init_byte = 8'h0C;  // display on, cursor off
            3'd4:             init_byte = 8'h01;  // clear
            default:          init_byte = 8'h06;  // entry mode, increment
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    d_q, d_d;
    logic          e_q, e_d;
    logic [2:0]    init_idx_q, init_idx_d;
    logic          init_done_q, init_done_d;
    logic          ovf_q, ovf_d;

    lcd_entry_t    wr_entry;
    lcd_entry_t    head;
    logic          head_vld;
    logic          pop_vld;
    logic          push_rdy;
    logic          load_init;
    logic          exec_long;

    assign wr_entry = '{rs: wr_rs, dat: wr_data};

    lcd1602_fifo #(
        .W     ($bits(lcd_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .in_clock (in_clock),
        .rst      (rst),
        .push_vld (wr_req),
        .push_rdy (push_rdy),
        .push_dat (wr_entry),
        .pop_vld  (pop_vld),
        .pop_rdy  (head_vld),
        .head_dat (head),
        .level    (fifo_level)
    );

    // Clear and return-home need the long execution time.
    assign exec_long = !rs_q && (d_q inside {[8'h01:8'h03]});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rs_d        = rs_q;
        d_d         = d_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        pop_vld     = 1'b0;
        load_init   = 1'b0;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == '0) load_init = 1'b1;
                else             cnt_d     = cnt_q - 1'b1;
            end
            ST_IDLE: begin
                if (head_vld) begin
                    pop_vld = 1'b1;
                    rs_d    = head.rs;
                    d_d     = head.dat;
                    state_d = ST_SETUP;
                    cnt_d   = CNT_SU;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_E_HIGH;
                    cnt_d   = CNT_EH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_E_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_EXEC;
                    cnt_d   = exec_long ? CNT_LONG : CNT_EXEC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (init_done_q) begin
                    state_d = ST_IDLE;
                end else if (init_idx_q == INIT_LEN) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    load_init = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_init) begin
            rs_d       = 1'b0;
            d_d        = init_byte(init_idx_q);
            init_idx_d = init_idx_q + 1'b1;
            state_d    = ST_SETUP;
            cnt_d      = CNT_SU;
        end
    end

    // E is a flop so the pin is glitch-free and drops with the async reset.
    assign e_d   = (state_d == ST_E_HIGH);
    // A drop in the same cycle as clr_ovf wins, so no overflow is ever lost.
    assign ovf_d = (wr_req && !push_rdy) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    always_ff @(posedge in_clock or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RESET;
            cnt_q       <= INIT_EN ? CNT_PWRUP : '0;
            rs_q        <= 1'b0;
            d_q         <= 8'h00;
            e_q         <= 1'b0;
            init_idx_q  <= 3'd0;
            init_done_q <= !INIT_EN;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            d_q         <= d_d;
            e_q         <= e_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy      = (state_q != ST_IDLE) || head_vld;
    assign overflow  = ovf_q;
    assign init_done = init_done_q;
    assign lcd_e     = e_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_d     = d_q;
endmodule
